// File: rtl/shared_reg_arbiter_pkg.sv
// Shared definitions for the shared-register arbiter.
// Holds the default values of N_REQ, WIDTH and MAX_HOLD, the two-state FSM
// enumeration, and a helper that sizes index/counter fields so a
// single-entry range still gets a one-bit field.
package shared_reg_arbiter_pkg;

  localparam int DEF_N_REQ    = 4;
  localparam int DEF_WIDTH    = 8;
  localparam int DEF_MAX_HOLD = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/shared_reg_arbiter_if.sv
// Bus bundle between N_REQ requesters and the shared-register arbiter.
//   req     : per-requester write request, held until served
//   lock    : per-requester request to keep ownership beyond one write
//   wdata   : packed write data, requester i at [i*WIDTH +: WIDTH]
//   grant   : registered one-hot ownership, zero when idle
//   ack     : write captured at the closing edge of this grant cycle
//   q       : shared register contents
//   owner   : index of current owner, zero when idle
//   timeout : one-cycle pulse after a forced release at MAX_HOLD
// master = requester side, slave = arbiter side.
interface shared_reg_arbiter_if
  import shared_reg_arbiter_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int WIDTH = DEF_WIDTH
) ();

  localparam int IDX_W = idx_w(N_REQ);

  logic [N_REQ-1:0]       req;
  logic [N_REQ-1:0]       lock;
  logic [N_REQ*WIDTH-1:0] wdata;
  logic [N_REQ-1:0]       grant;
  logic                   ack;
  logic [WIDTH-1:0]       q;
  logic [IDX_W-1:0]       owner;
  logic                   timeout;

  modport master (
    output req, lock, wdata,
    input  grant, ack, q, owner, timeout
  );

  modport slave (
    input  req, lock, wdata,
    output grant, ack, q, owner, timeout
  );

endinterface

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req    : request vector
//   ptr    : highest-priority requester index for this pick
//   winner : one-hot of the first requester at or after ptr (wrapping)
//   index  : binary index of winner
//   valid  : at least one request present
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] winner,
  output logic [IDX_W-1:0] index,
  output logic             valid
);

  localparam int SUM_W = IDX_W + 1;

  logic [SUM_W-1:0] sum;
  logic [IDX_W-1:0] cand;

  always_comb begin
    winner = '0;
    index  = '0;
    valid  = 1'b0;
    sum    = '0;
    cand   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      // ptr + i reduced modulo N_REQ; one extra bit keeps the carry visible
      sum = {1'b0, ptr} + SUM_W'(i);
      if (sum >= SUM_W'(N_REQ)) begin
        sum = sum - SUM_W'(N_REQ);
      end
      cand = sum[IDX_W-1:0];
      if (!valid && req[cand]) begin
        valid        = 1'b1;
        index        = cand;
        winner[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Shared D-register with round-robin ownership arbitration.
//   clock : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : slave side of shared_reg_arbiter_if (req/lock/wdata in,
//           grant/ack/q/owner/timeout out)
// An owner writes q in every grant cycle where its req is high. With lock
// it may keep ownership for up to MAX_HOLD consecutive cycles; every
// release passes through one IDLE cycle before the next owner is chosen.
module shared_reg_arbiter
  import shared_reg_arbiter_pkg::*;
#(
  parameter int N_REQ    = DEF_N_REQ,
  parameter int WIDTH    = DEF_WIDTH,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input logic                  clock,
  input logic                  reset,
  shared_reg_arbiter_if.slave  bus
);

  localparam int IDX_W  = idx_w(N_REQ);
  localparam int HOLD_W = idx_w(MAX_HOLD);

  state_t            state, state_nxt;
  logic [N_REQ-1:0]  grant_r, grant_nxt;
  logic [IDX_W-1:0]  owner_r, owner_nxt;
  logic [IDX_W-1:0]  ptr_r, ptr_nxt;
  logic [HOLD_W-1:0] hold_r, hold_nxt;
  logic [WIDTH-1:0]  q_r, q_nxt;
  logic              timeout_r, timeout_nxt;

  logic [N_REQ-1:0]  pick_oh;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_vld;
  logic              owner_req;
  logic              owner_lock;
  logic              hold_more;
  logic [IDX_W-1:0]  ptr_after;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req    (bus.req),
    .ptr    (ptr_r),
    .winner (pick_oh),
    .index  (pick_idx),
    .valid  (pick_vld)
  );

  // owner_r is 0 while idle; these are only consumed in ST_GRANT
  assign owner_req  = bus.req[owner_r];
  assign owner_lock = bus.lock[owner_r];
  assign hold_more  = owner_lock && (hold_r < HOLD_W'(MAX_HOLD - 1));
  assign ptr_after  = (owner_r == IDX_W'(N_REQ - 1)) ? '0 : owner_r + IDX_W'(1);

  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant_r;
    owner_nxt   = owner_r;
    ptr_nxt     = ptr_r;
    hold_nxt    = hold_r;
    q_nxt       = q_r;
    timeout_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_vld) begin
          state_nxt = ST_GRANT;
          grant_nxt = pick_oh;
          owner_nxt = pick_idx;
          hold_nxt  = '0;
        end
      end
      ST_GRANT: begin
        if (owner_req) begin
          q_nxt = bus.wdata[int'(owner_r)*WIDTH +: WIDTH];
        end
        if (owner_req && hold_more) begin
          hold_nxt = hold_r + HOLD_W'(1);
        end else begin
          // abort, plain single write, or forced release at the hold limit
          state_nxt   = ST_IDLE;
          grant_nxt   = '0;
          owner_nxt   = '0;
          ptr_nxt     = ptr_after;
          hold_nxt    = '0;
          timeout_nxt = owner_req && owner_lock;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        grant_nxt = '0;
        owner_nxt = '0;
      end
    endcase
  end

  // ---- state / output register boundary ----
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      grant_r   <= '0;
      owner_r   <= '0;
      ptr_r     <= '0;
      hold_r    <= '0;
      q_r       <= '0;
      timeout_r <= 1'b0;
    end else begin
      state     <= state_nxt;
      grant_r   <= grant_nxt;
      owner_r   <= owner_nxt;
      ptr_r     <= ptr_nxt;
      hold_r    <= hold_nxt;
      q_r       <= q_nxt;
      timeout_r <= timeout_nxt;
    end
  end

  assign bus.grant   = grant_r;
  assign bus.owner   = owner_r;
  assign bus.q       = q_r;
  assign bus.timeout = timeout_r;
  assign bus.ack     = (state == ST_GRANT) && owner_req;

endmodule
